multu_sequencer: RTL
====================

Name: multu_sequencer

Overview:
- Sequencing controller for the shift-add multiplier datapath: accepts a MULTU request on the shared 6-bit `ctl` bus and runs 32 add/shift iterations.
- Latches the 64-bit product into architectural HI/LO and serves MFHI/MFLO/MTHI/MTLO.
- Sits beside the ALU in the execute stage. Raises `busy` so the pipeline stalls HI/LO readers until the product is valid.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- ctl  in  6  function code: MULTU=25, MFHI=16, MTHI=17, MFLO=18, MTLO=19, MULT=24
- start  in  1  qualifies `ctl`/`a`/`b` for this cycle
- a  in  WIDTH  multiplicand, or MTHI/MTLO source
- b  in  WIDTH  multiplier
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse: HI/LO just updated by a multiply
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO
- result  out  WIDTH  combinational: HI when ctl=MFHI, LO when ctl=MFLO, else 0

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0.
  - Counter and internal multiplicand/multiplier/product registers = 0.
  - Reset mid-operation abandons the multiply; HI/LO stay 0.
- States:
  - IDLE: `busy`=0.
    - start & ctl=MULTU at edge E: load mcand={32'b0,a}, mplr=b, prod=0, cnt=0; go to RUN.
    - start & MTHI: hi<=a. start & MTLO: lo<=a. Both take effect at the edge and stay in IDLE.
    - Any other code: no state change.
  - RUN: `busy`=1. Each edge performs one iteration:
    - if mplr[0], prod<=prod+mcand (64-bit, carry out of bit 63 discarded);
    - mcand<=mcand<<1; mplr<=mplr>>1; cnt<=cnt+1.
    - On the edge where cnt==31: write {hi,lo}<=final prod, including that iteration's add; go to DONE.
  - DONE: `done`=1, `busy`=0 for exactly one cycle, then IDLE.
    - A start accepted in DONE is ignored.
- Latency: a MULTU accepted at edge E0 gives RUN during cycles E0..E32, HI/LO visible after edge E32, and `done` high between E32 and E33. Fixed latency, no early exit, even for zero operands.
- During RUN:
  - Any start is ignored: no queueing, no restart, MTHI/MTLO discarded. The issuing stage must honour `busy`.
  - MFHI/MFLO return the old HI/LO; the stall is the pipeline's duty.
- `result` is purely combinational from `ctl` and HI/LO and does not depend on `start`.
- `done` and `busy` are never both 1.

Optional Feature:
- Macro: MULTU_SEQUENCER_SIGNED_EN.
- Defined: ctl=MULT (24) is accepted like MULTU.
  - Operands are converted to magnitudes at load, and a 1-bit neg flag = a[31]^b[31] is latched.
  - On the final edge, {hi,lo} <= neg ? -prod : prod (two's complement over 64 bits).
  - Latency is identical to MULTU.
- Undefined: ctl=24 is treated as an unrecognised code (no effect), and no neg flag or negation logic is built.

Decomposition:
- Package muldiv_pkg:
  - function-code localparams (MULTU, MULT, MFHI, MTHI, MFLO, MTLO);
  - state encoding IDLE/RUN/DONE as a 2-bit typedef;
  - ITERATIONS=32.
- One natural sub-module: multu_step, the combinational single-iteration datapath.
  - Inputs: prod, mcand, mplr.
  - Outputs: next prod, mcand, mplr.
  - Lets the verification bench check the iteration in isolation.
- FSM, counter, HI/LO registers and the result mux stay in multu_sequencer.

Test Plan:
- rst=0 for 2 cycles, then release -> hi=lo=0, busy=0, done=0. rst=0 asserted mid-RUN -> outputs 0 immediately, without waiting for a clock edge.
- MULTU a=3, b=5 at E0 -> busy over E0..E32, done pulse after E32, hi=0x00000000, lo=0x0000000F; then ctl=MFLO -> result=0x0000000F.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- MTHI a=0x12345678, then MULTU a=2, b=2; MULTU a=9, b=9 issued at cycle 10 of RUN -> second request ignored, final hi=0, lo=4; MFHI during RUN returns 0x12345678.
- MULTU a=0, b=0 -> still exactly 33 edges to done, hi=lo=0. MTLO issued in the DONE cycle -> ignored.
- With MULTU_SEQUENCER_SIGNED_EN: MULT a=0xFFFFFFFD (−3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without the macro: the same stimulus leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared codes and state encoding for the HI/LO multiply unit.
// Optional signed MULT support is selected with MULTU_SEQUENCER_SIGNED_EN.
`timescale 1ns/1ps
package muldiv_pkg;

  localparam logic [5:0] MFHI  = 6'd16;
  localparam logic [5:0] MTHI  = 6'd17;
  localparam logic [5:0] MFLO  = 6'd18;
  localparam logic [5:0] MTLO  = 6'd19;
  localparam logic [5:0] MULT  = 6'd24;
  localparam logic [5:0] MULTU = 6'd25;

  localparam int ITERATIONS = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/multu_step.sv
// One shift-add iteration of the multiplier datapath.
// Purely combinational; the sequencer registers its outputs.
`timescale 1ns/1ps
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplr,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplr
);

  assign o_prod  = i_mplr[0] ? i_prod + i_mcand
                             : i_prod;
  assign o_mcand = i_mcand << 1;
  assign o_mplr  = i_mplr >> 1;

endmodule

// File: rtl/multu_sequencer.sv
// HI/LO multiply sequencer: 32-step shift-add MULTU plus MFHI/MFLO/MTHI/MTLO.
// Define MULTU_SEQUENCER_SIGNED_EN to also accept signed MULT.
`timescale 1ns/1ps
module multu_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ctl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [2*WIDTH-1:0] w_next_prod;
  logic [2*WIDTH-1:0] w_next_mcand;
  logic [WIDTH-1:0]   w_next_mplr;
  logic [2*WIDTH-1:0] w_final;
  logic               w_is_mul;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

`ifdef MULTU_SEQUENCER_SIGNED_EN
  logic r_neg;
  logic w_signed;

  assign w_signed = (ctl == MULT);
  assign w_is_mul = (ctl == MULTU) || w_signed;
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;
  assign w_final  = r_neg ? -w_next_prod : w_next_prod;

  // Sign of a signed product, captured with the operands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_neg <= 1'b0;
    end else if (r_state == S_IDLE && start && w_is_mul) begin
      r_neg <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
  end
`else
  assign w_is_mul = (ctl == MULTU);
  assign w_mag_a  = a;
  assign w_mag_b  = b;
  assign w_final  = w_next_prod;
`endif

  multu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_prod  (r_prod),
    .i_mcand (r_mcand),
    .i_mplr  (r_mplr),
    .o_prod  (w_next_prod),
    .o_mcand (w_next_mcand),
    .o_mplr  (w_next_mplr)
  );

  // Control FSM, iteration registers and architectural HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prod  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
              r_mplr  <= w_mag_b;
              r_prod  <= '0;
              r_cnt   <= '0;
              r_state <= S_RUN;
            end else if (ctl == MTHI) begin
              r_hi <= a;
            end else if (ctl == MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_RUN: begin
          r_prod  <= w_next_prod;
          r_mcand <= w_next_mcand;
          r_mplr  <= w_next_mplr;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            {r_hi, r_lo} <= w_final;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // HI/LO read port selected by the function code alone.
  always_comb begin
    result = '0;
    if (ctl == MFHI) begin
      result = r_hi;
    end else if (ctl == MFLO) begin
      result = r_lo;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
